// File: rtl/citi_out_capture_if.sv
// Output stream of citi_out_capture: sign-extended sample, index tag, valid/ready.
// Ports: dout, dout_tag, dout_valid (producer -> consumer), dout_ready (consumer -> producer).
// The master modport is the capture block; the slave modport is the result sink.
interface citi_out_capture_if #(
    parameter int OUT_W = 32,
    parameter int TAG_W = 3
);
    logic [OUT_W-1:0] dout;
    logic [TAG_W-1:0] dout_tag;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dout,
        output dout_tag,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_tag,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/citi_out_capture.sv
// Captures the citi filter output once per OSR-clock sample period, tags it, queues it in a FWFT FIFO.
// Latency: capture edge -> dout_valid in the next cycle when the FIFO was empty.
// Backpressure: dout_ready stalls the FIFO; a capture into a full FIFO (no pop) is dropped and sets overflow.
//
// Ports:
//   clk30x, rst        : clock (rising edge) and asynchronous active-high reset
//   yin                : two's-complement filter output, sampled when the phase counter hits CAP_PHASE
//   sync               : realign pulse, restarts phase and tag, suppresses capture on that edge
//   clr                : synchronous clear of overflow (and peak_abs)
//   result             : master side of citi_out_capture_if (dout, dout_tag, dout_valid, dout_ready)
//   fifo_count         : current FIFO occupancy, 0..FIFO_DEPTH
//   overflow           : sticky dropped-sample flag
//   peak_abs           : only with CITI_OUT_PEAK_EN defined; running max of |yin| over captures
//
// Optional feature macro: CITI_OUT_PEAK_EN (undefined by default, port and logic absent).
module citi_out_capture #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 32,
    parameter int OSR        = 30,
    parameter int CAP_PHASE  = 29,
    parameter int FRAME_LEN  = 8,
    parameter int TAG_W      = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk30x,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             yin,
    input  logic                          sync,
    input  logic                          clr,
    citi_out_capture_if.master            result,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
`ifdef CITI_OUT_PEAK_EN
    ,
    output logic [DATA_W-2:0]             peak_abs
`endif
);

    localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0]  PH_CAP   = PH_W'(CAP_PHASE);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(FRAME_LEN - 1);
    localparam logic [AW:0]      CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Sample-period timing: phase counter and sample index tag
    // ------------------------------------------------------------------
    logic [PH_W-1:0]  phase;
    logic [TAG_W-1:0] tag;
    logic             capture;

    // Sync wins over capture so a realign never produces a half-period sample.
    assign capture = !sync && (phase == PH_CAP);

    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            phase <= '0;
            tag   <= '0;
        end else if (sync) begin
            phase <= '0;
            tag   <= '0;
        end else begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            // The tag counts sample periods, not stored samples, so it
            // advances even when the FIFO drops the entry.
            if (capture) begin
                tag <= (tag == TAG_LAST) ? '0 : tag + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    // Samples are stored at DATA_W and sign-extended on the way out.
    logic [DATA_W-1:0] mem_dat [FIFO_DEPTH];
    logic [TAG_W-1:0]  mem_tag [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign pop   = !empty && result.dout_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            // Storage is cleared too so dout/dout_tag read 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_dat[i] <= '0;
                mem_tag[i] <= '0;
            end
        end else if (push) begin
            // When full with a simultaneous pop, wr_ptr == rd_ptr and this
            // overwrites the head that is leaving on this same edge.
            mem_dat[wr_ptr] <= yin;
            mem_tag[wr_ptr] <= tag;
        end
    end

    // Pointers are AW bits wide so they wrap modulo the power-of-two depth.
    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop on the same edge as clr keeps the flag set so it is never lost.
    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    assign result.dout       = OUT_W'($signed(mem_dat[rd_ptr]));
    assign result.dout_tag   = mem_tag[rd_ptr];
    assign result.dout_valid = !empty;
    assign fifo_count        = count;

`ifdef CITI_OUT_PEAK_EN
    // ------------------------------------------------------------------
    // Peak magnitude tracker, updated on every capture including drops
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] yin_mag;
    logic [DATA_W-2:0] yin_abs;

    assign yin_mag = yin[DATA_W-1] ? (~yin + 1'b1) : yin;
    // Only the most negative code leaves the MSB set after negation;
    // saturate it to the largest representable magnitude.
    assign yin_abs = yin_mag[DATA_W-1] ? '1 : yin_mag[DATA_W-2:0];

    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            peak_abs <= '0;
        end else if (capture) begin
            // With clr the running max restarts from this sample.
            if (clr || (yin_abs > peak_abs)) begin
                peak_abs <= yin_abs;
            end
        end else if (clr) begin
            peak_abs <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_citi_out_capture.sv
module tb_citi_out_capture;

    localparam int DATA_W     = 16;
    localparam int OUT_W      = 32;
    localparam int OSR        = 30;
    localparam int CAP_PHASE  = 29;
    localparam int FRAME_LEN  = 8;
    localparam int TAG_W      = 3;
    localparam int FIFO_DEPTH = 8;

    logic              clk30x = 1'b0;
    logic              rst    = 1'b1;
    logic [DATA_W-1:0] yin    = '0;
    logic              sync   = 1'b0;
    logic              clr    = 1'b0;
    logic [3:0]        fifo_count;
    logic              overflow;
`ifdef CITI_OUT_PEAK_EN
    logic [DATA_W-2:0] peak_abs;
`endif

    citi_out_capture_if #(.OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    citi_out_capture #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .OSR(OSR), .CAP_PHASE(CAP_PHASE),
        .FRAME_LEN(FRAME_LEN), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk30x     (clk30x),
        .rst        (rst),
        .yin        (yin),
        .sync       (sync),
        .clr        (clr),
        .result     (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef CITI_OUT_PEAK_EN
        ,
        .peak_abs   (peak_abs)
`endif
    );

    always #5 clk30x = ~clk30x;

    // ------------------------------------------------------------------
    // Reference model: edges since alignment, captures since alignment,
    // a queue of stored samples, sticky flag and running peak.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] d;
        int          tag;
    } ent_t;

    ent_t q[$];
    int   k;
    int   ncap;
    bit   m_ov;
    int   m_peak;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        k      = 0;
        ncap   = 0;
        m_ov   = 1'b0;
        m_peak = 0;
    endtask

    task automatic check_state();
        check("valid", {63'd0, bus.dout_valid}, {63'd0, q.size() != 0});
        check("count", {60'd0, fifo_count}, 64'(q.size()));
        check("overflow", {63'd0, overflow}, {63'd0, m_ov});
        if (q.size() != 0) begin
            check("dout", {32'd0, bus.dout}, {32'd0, q[0].d});
            check("dout_tag", {61'd0, bus.dout_tag}, 64'(q[0].tag));
        end
`ifdef CITI_OUT_PEAK_EN
        check("peak_abs", {49'd0, peak_abs}, 64'(m_peak));
`endif
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare shortly after the edge.
    task automatic tick();
        bit   cap;
        bit   pop;
        bit   push;
        ent_t e;
        int   v;
        int   a;
        @(posedge clk30x);
        if (rst) begin
            model_reset();
        end else begin
            cap  = !sync && ((k % OSR) == CAP_PHASE);
            pop  = (q.size() > 0) && bus.dout_ready;
            push = cap && ((q.size() < FIFO_DEPTH) || pop);
            v    = $signed(yin);
            if (pop) e = q.pop_front();
            if (push) begin
                e.d   = v;
                e.tag = ncap % FRAME_LEN;
                q.push_back(e);
            end
            if (cap && !push) m_ov = 1'b1;
            else if (clr)     m_ov = 1'b0;
            a = (v < 0) ? -v : v;
            if (a > 32767) a = 32767;
            if (cap) m_peak = (clr || a > m_peak) ? a : m_peak;
            else if (clr) m_peak = 0;
            if (cap) ncap++;
            if (sync) begin
                k    = 0;
                ncap = 0;
            end else begin
                k++;
            end
        end
        #1;
        check_state();
    endtask

    // Advance until the next edge would be seen at phase p.
    task automatic go_until_phase(input int p);
        int n = 0;
        while (((k % OSR) != p) && (n < 200)) begin
            tick();
            n++;
        end
        check("phase_bound", {63'd0, n < 200}, 64'd1);
    endtask

    task automatic capture_one();
        go_until_phase(CAP_PHASE);
        tick();
    endtask

    initial begin
        bus.dout_ready = 1'b1;
        model_reset();

        // Reset state
        #12;
        check("rst_dout", {32'd0, bus.dout}, 64'd0);
        check("rst_tag", {61'd0, bus.dout_tag}, 64'd0);
        check("rst_valid", {63'd0, bus.dout_valid}, 64'd0);
        check("rst_count", {60'd0, fifo_count}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);

        // Test 1: first capture on edge 30, tag progression and wrap
        yin = 16'h0005;
        @(negedge clk30x);
        rst = 1'b0;
        model_reset();
        repeat (29) tick();
        check("t1_no_cap_e29", {63'd0, bus.dout_valid}, 64'd0);
        tick();
        check("t1_valid_e30", {63'd0, bus.dout_valid}, 64'd1);
        check("t1_dout_e30", {32'd0, bus.dout}, 64'h0000_0005);
        check("t1_tag_e30", {61'd0, bus.dout_tag}, 64'd0);
        repeat (30) tick();
        check("t1_valid_e60", {63'd0, bus.dout_valid}, 64'd1);
        check("t1_tag_e60", {61'd0, bus.dout_tag}, 64'd1);
        repeat (210) tick();
        check("t1_valid_e270", {63'd0, bus.dout_valid}, 64'd1);
        check("t1_tag_wrap", {61'd0, bus.dout_tag}, 64'd0);

        // Test 2: sign extension extremes
        yin = 16'h8000;
        capture_one();
        check("t2_neg_ext", {32'd0, bus.dout}, 64'hFFFF_8000);
        yin = 16'h7FFF;
        capture_one();
        check("t2_pos_ext", {32'd0, bus.dout}, 64'h0000_7FFF);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            yin            = 16'($urandom);
            bus.dout_ready = ($urandom_range(0, 9) < 3);
            clr            = ($urandom_range(0, 49) == 0);
            sync           = ($urandom_range(0, 199) == 0);
            tick();
        end
        clr  = 1'b0;
        sync = 1'b0;

        // Test 4: sync at phase 15 suppresses the pending capture
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        yin = 16'h1234;
        go_until_phase(15);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (14) tick();
        check("t4_no_cap_old_phase", {63'd0, bus.dout_valid}, 64'd0);
        repeat (15) tick();
        check("t4_no_cap_e29", {63'd0, bus.dout_valid}, 64'd0);
        tick();
        check("t4_cap_e30", {63'd0, bus.dout_valid}, 64'd1);
        check("t4_tag0", {61'd0, bus.dout_tag}, 64'd0);
        tick();

        // Test 3: fill, drop, clr-vs-drop, ordered drain
        go_until_phase(5);
        sync           = 1'b1;
        bus.dout_ready = 1'b0;
        tick();
        sync = 1'b0;
        for (int i = 0; i < 9; i++) begin
            yin = 16'(100 + i);
            capture_one();
        end
        check("t3_full_count", {60'd0, fifo_count}, 64'd8);
        check("t3_overflow", {63'd0, overflow}, 64'd1);
        go_until_phase(CAP_PHASE);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_clr_vs_drop", {63'd0, overflow}, 64'd1);
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_valid", {63'd0, bus.dout_valid}, 64'd1);
            check("t3_drain_tag", {61'd0, bus.dout_tag}, 64'(i));
            check("t3_drain_dout", {32'd0, bus.dout}, 64'(100 + i));
            tick();
        end
        check("t3_empty", {60'd0, fifo_count}, 64'd0);
        check("t3_ov_sticky", {63'd0, overflow}, 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_ov_cleared", {63'd0, overflow}, 64'd0);

        // Full FIFO with pop and capture on the same edge
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            yin = 16'($urandom);
            capture_one();
        end
        go_until_phase(CAP_PHASE);
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        check("full_pushpop_count", {60'd0, fifo_count}, 64'd8);
        check("full_pushpop_ov", {63'd0, overflow}, 64'd0);

        // Count 1 with pop and capture on the same edge
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        bus.dout_ready = 1'b0;
        yin = 16'hABCD;
        capture_one();
        yin = 16'h0777;
        go_until_phase(CAP_PHASE);
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        check("one_replace_count", {60'd0, fifo_count}, 64'd1);
        check("one_replace_dout", {32'd0, bus.dout}, 64'h0000_0777);

        // Test 5: asynchronous reset mid-cycle with entries queued
        capture_one();
        capture_one();
        check("t5_count3", {60'd0, fifo_count}, 64'd3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t5_async_valid", {63'd0, bus.dout_valid}, 64'd0);
        check("t5_async_count", {60'd0, fifo_count}, 64'd0);
        tick();
        #2;
        rst = 1'b0;
        repeat (29) tick();
        check("t5_no_cap_e29", {63'd0, bus.dout_valid}, 64'd0);
        tick();
        check("t5_cap_e30", {63'd0, bus.dout_valid}, 64'd1);
        check("t5_tag0", {61'd0, bus.dout_tag}, 64'd0);

`ifdef CITI_OUT_PEAK_EN
        // Test 6: peak magnitude tracking
        bus.dout_ready = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_peak_clr0", {49'd0, peak_abs}, 64'd0);
        yin = 16'd100;
        capture_one();
        yin = 16'hFED4;
        capture_one();
        yin = 16'd200;
        capture_one();
        check("t6_peak_300", {49'd0, peak_abs}, 64'd300);
        yin = 16'h8000;
        capture_one();
        check("t6_peak_sat", {49'd0, peak_abs}, 64'd32767);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_peak_clr", {49'd0, peak_abs}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
